clk_div_bank: RTL and testbench
===============================

// Module: clk_div_bank
// PURPOSE
//  Multi-channel programmable clock-enable / slow-clock generator; NUM_CH independent dividers off SYS_CLK.
//  Each channel has a runtime-writable divider and mode, glitch-free reprogramming and an enable.
//  Feeds LCD/LED/debounce timing logic.
//  Outputs are SYS_CLK-domain enables/levels, never used as real clocks.
// PARAMETERS
//  NUM_CH       4        number of divider channels (1..16)
//  CNT_W        28       counter / divider width
//  DEFAULT_DIV  6250000  divider loaded into every channel at reset (sim benches use 5)
// PORTS
//  SYS_CLK   in   1                   system clock; all logic on rising edge
//  SYS_RST   in   1                   synchronous, active-high reset
//  CH_EN     in   NUM_CH              per-channel run enable
//  CFG_WE    in   1                   config write strobe, single cycle
//  CFG_CH    in   max(1,$clog2(NUM_CH))  target channel of write
//  CFG_DIV   in   CNT_W               new divider value
//  CFG_MODE  in   1                   0 = toggle (square wave), 1 = pulse
//  TICK      out  NUM_CH              1-cycle pulse per channel at terminal count
//  SLOW_CLK  out  NUM_CH              per-channel slow output (toggle level, or pulse in mode 1)
// BEHAVIOUR
//  - Reset (SYS_RST=1 at an edge): counters=0; active_div=pending_div=DEFAULT_DIV; mode=0.
//    TICK=0, SLOW_CLK=0 from the next cycle; reset mid-period aborts the period; CFG_WE ignored during reset.
//  - Per-channel state: IDLE (CH_EN=0) / RUN (CH_EN=1); evaluated from CH_EN each edge.
//  - IDLE: counter held at start value (0); TICK=0, SLOW_CLK=0; active_div<=pending_div every cycle.
//  - RUN: counter increments by 1 per edge. When counter==active_div (terminal):
//    counter<=0; TICK<=1 for exactly one cycle; active_div<=pending_div; mode applied.
//  - Latency: TICK asserts after active_div+1 edges with CH_EN=1, measured from IDLE. Period = div+1 cycles.
//  - Mode 0: SLOW_CLK toggles at each terminal; output period = 2*(div+1) cycles, 50% duty.
//  - Mode 1: SLOW_CLK == TICK (registered identically).
//  - div=0: terminal every cycle; TICK stuck 1; mode-0 SLOW_CLK = SYS_CLK/2.
//  - Config write: CFG_WE=1 and CFG_CH<NUM_CH -> pending_div/pending_mode of that channel <= CFG_DIV/CFG_MODE.
//    CFG_CH>=NUM_CH is ignored. Multiple writes before a terminal: last wins.
//  - Write on the same edge as a terminal: the terminal loads the OLD pending value.
//    The new value takes effect at the following terminal (or immediately if IDLE).
//  - Mode change at a terminal: SLOW_CLK takes the new mode's value on that edge. Toggle level restarts at 1.
//  - CH_EN falling mid-count: next edge IDLE, outputs 0, no partial TICK.
//    Re-enable restarts a full period.
//  - Counter never exceeds active_div; no wrap at 2^CNT_W.
//    Channels fully independent; simultaneous terminals on several channels are allowed.
// CONFIGURATION
//  CLKDIV_PHASE_EN defined:
//   - adds port CFG_PHASE in CNT_W, written with CFG_WE into pending_phase (reset 0).
//   - IDLE counter start value = min(pending_phase, pending_div).
//   - first TICK after active_div-start+1 edges; later periods start from 0.
//   - phase>div clamps to div: TICK on first RUN edge.
//  CLKDIV_PHASE_EN undefined: CFG_PHASE port absent; start value always 0.
// TESTING
//  1. NUM_CH=2, DEFAULT_DIV=5, reset, CH_EN=01 -> ch0 TICK 1-cycle high on edges 6,12,18.
//     ch0 SLOW_CLK high edges 6-11, low 12-17; ch1 outputs stay 0.
//  2. Write ch1 DIV=0 MODE=0, CH_EN=11 -> ch1 TICK constant 1, SLOW_CLK toggles every cycle.
//  3. ch0 running DIV=5, write DIV=2 at counter=2 -> current period ends at counter 5.
//     Subsequent TICKs every 3 cycles. Repeat with write on terminal edge -> one extra 6-cycle period.
//  4. Write MODE=1 DIV=3 -> SLOW_CLK==TICK, one high cycle every 4; CFG_CH=3 with NUM_CH=2 -> no state change.
//  5. CH_EN drop at counter=3 -> outputs 0 next cycle.
//     Re-enable -> first TICK after 6 edges. SYS_RST at counter=4 -> all outputs 0, DIV back to 5.
//  6. CLKDIV_PHASE_EN: DIV=5 PHASE=4 -> first TICK 2 edges after enable, then every 6.
//     PHASE=9 -> TICK on first edge.

Source files
------------

// File: rtl/clk_div_bank_if.sv
// Configuration and output bundle for clk_div_bank.
// Optional feature macro: CLKDIV_PHASE_EN (adds the CFG_PHASE field).
interface clk_div_bank_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 28
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0] CH_EN;
   logic              CFG_WE;
   logic [CH_W-1:0]   CFG_CH;
   logic [CNT_W-1:0]  CFG_DIV;
   logic              CFG_MODE;
`ifdef CLKDIV_PHASE_EN
   logic [CNT_W-1:0]  CFG_PHASE;
`endif
   logic [NUM_CH-1:0] TICK;
   logic [NUM_CH-1:0] SLOW_CLK;

`ifdef CLKDIV_PHASE_EN
   modport master (output CH_EN, CFG_WE, CFG_CH, CFG_DIV, CFG_MODE, CFG_PHASE,
                   input  TICK, SLOW_CLK);
   modport slave  (input  CH_EN, CFG_WE, CFG_CH, CFG_DIV, CFG_MODE, CFG_PHASE,
                   output TICK, SLOW_CLK);
`else
   modport master (output CH_EN, CFG_WE, CFG_CH, CFG_DIV, CFG_MODE,
                   input  TICK, SLOW_CLK);
   modport slave  (input  CH_EN, CFG_WE, CFG_CH, CFG_DIV, CFG_MODE,
                   output TICK, SLOW_CLK);
`endif
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent programmable clock-enable generators.
// Each channel counts SYS_CLK edges up to its active divider, emits a one-cycle
// TICK at terminal count and drives SLOW_CLK as a toggle level or a pulse.
// Divider/mode writes land in a pending register and are adopted at the next
// terminal count (or continuously while the channel is idle).
// Optional feature macro: CLKDIV_PHASE_EN (per-channel start phase).
module clk_div_bank #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 28,
   parameter int DEFAULT_DIV = 6250000
) (
   input  logic          SYS_CLK,
   input  logic          SYS_RST,
   clk_div_bank_if.slave bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t            r_state      [NUM_CH];
   logic [CNT_W-1:0]  r_cnt        [NUM_CH];
   logic [CNT_W-1:0]  r_activeDiv  [NUM_CH];
   logic [CNT_W-1:0]  r_pendDiv    [NUM_CH];
   logic              r_activeMode [NUM_CH];
   logic              r_pendMode   [NUM_CH];
`ifdef CLKDIV_PHASE_EN
   logic [CNT_W-1:0]  r_pendPhase  [NUM_CH];
`endif
   logic [NUM_CH-1:0] r_tick;
   logic [NUM_CH-1:0] r_slow;

   state_t            w_nextState      [NUM_CH];
   logic [CNT_W-1:0]  w_nextCnt        [NUM_CH];
   logic [CNT_W-1:0]  w_nextActiveDiv  [NUM_CH];
   logic              w_nextActiveMode [NUM_CH];
   logic [CNT_W-1:0]  w_startCnt       [NUM_CH];
   logic [NUM_CH-1:0] w_nextTick;
   logic [NUM_CH-1:0] w_nextSlow;

   // Idle start value of each counter: zero, or the clamped start phase when enabled.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
`ifdef CLKDIV_PHASE_EN
         w_startCnt[i] = (r_pendPhase[i] < r_pendDiv[i]) ? r_pendPhase[i] : r_pendDiv[i];
`else
         w_startCnt[i] = '0;
`endif
      end
   end

   // Per-channel next state and datapath: idle holds/reloads, run counts and fires at terminal.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_nextState[i]      = r_state[i];
         w_nextCnt[i]        = r_cnt[i];
         w_nextActiveDiv[i]  = r_activeDiv[i];
         w_nextActiveMode[i] = r_activeMode[i];
         w_nextTick[i]       = 1'b0;
         w_nextSlow[i]       = r_slow[i];

         case (r_state[i])
            ST_IDLE: if (bus.CH_EN[i])  w_nextState[i] = ST_RUN;
            ST_RUN:  if (!bus.CH_EN[i]) w_nextState[i] = ST_IDLE;
            default: w_nextState[i] = ST_IDLE;
         endcase

         if (w_nextState[i] == ST_IDLE) begin
            w_nextCnt[i]        = w_startCnt[i];
            w_nextActiveDiv[i]  = r_pendDiv[i];
            w_nextActiveMode[i] = r_pendMode[i];
            w_nextSlow[i]       = 1'b0;
         end else if (r_cnt[i] >= r_activeDiv[i]) begin
            w_nextCnt[i]        = '0;
            w_nextTick[i]       = 1'b1;
            w_nextActiveDiv[i]  = r_pendDiv[i];
            w_nextActiveMode[i] = r_pendMode[i];
            if (r_pendMode[i] || r_activeMode[i]) begin
               w_nextSlow[i] = 1'b1;
            end else begin
               w_nextSlow[i] = ~r_slow[i];
            end
         end else begin
            w_nextCnt[i] = r_cnt[i] + CNT_W'(1);
            if (r_activeMode[i]) begin
               w_nextSlow[i] = 1'b0;
            end
         end
      end
   end

   // State registers plus config capture; writes to a non-existent channel are dropped.
   always_ff @(posedge SYS_CLK) begin
      if (SYS_RST) begin
         r_tick <= '0;
         r_slow <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i]      <= ST_IDLE;
            r_cnt[i]        <= '0;
            r_activeDiv[i]  <= CNT_W'(DEFAULT_DIV);
            r_pendDiv[i]    <= CNT_W'(DEFAULT_DIV);
            r_activeMode[i] <= 1'b0;
            r_pendMode[i]   <= 1'b0;
`ifdef CLKDIV_PHASE_EN
            r_pendPhase[i]  <= '0;
`endif
         end
      end else begin
         r_tick <= w_nextTick;
         r_slow <= w_nextSlow;
         for (int i = 0; i < NUM_CH; i++) begin
            r_state[i]      <= w_nextState[i];
            r_cnt[i]        <= w_nextCnt[i];
            r_activeDiv[i]  <= w_nextActiveDiv[i];
            r_activeMode[i] <= w_nextActiveMode[i];
            if (bus.CFG_WE && (bus.CFG_CH == CH_W'(i))) begin
               r_pendDiv[i]   <= bus.CFG_DIV;
               r_pendMode[i]  <= bus.CFG_MODE;
`ifdef CLKDIV_PHASE_EN
               r_pendPhase[i] <= bus.CFG_PHASE;
`endif
            end
         end
      end
   end

   assign bus.TICK     = r_tick;
   assign bus.SLOW_CLK = r_slow;
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed scoreboard bench for clk_div_bank (3 channels, 8-bit counters, DEFAULT_DIV=5).
// Stimulus pushes per-edge expected TICK/SLOW_CLK vectors; the monitor pops and compares.
// Define CLKDIV_PHASE_EN to also exercise the start-phase feature.
module tb_clk_div_bank;
   localparam int NUM_CH      = 3;
   localparam int CNT_W       = 8;
   localparam int DEFAULT_DIV = 5;

   logic SYS_CLK = 1'b0;
   logic SYS_RST;

   // Free-running system clock.
   always #5 SYS_CLK = ~SYS_CLK;

   clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   clk_div_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
      .SYS_CLK (SYS_CLK),
      .SYS_RST (SYS_RST),
      .bus     (bus)
   );

   typedef struct {
      int         cyc;
      logic [2:0] tick;
      logic [2:0] slow;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   tickList[$];
   int   edgeCnt = 0;
   int   checks  = 0;
   int   errors  = 0;

   // Count rising edges so each expectation can be tied to the edge it describes.
   always @(posedge SYS_CLK) edgeCnt <= edgeCnt + 1;

   task automatic applyStimulus(input logic rst, input logic [2:0] en, input logic we,
                                input logic [1:0] ch, input int div, input logic mode,
                                input int phase);
      @(negedge SYS_CLK);
      SYS_RST      = rst;
      bus.CH_EN    = en;
      bus.CFG_WE   = we;
      bus.CFG_CH   = ch;
      bus.CFG_DIV  = CNT_W'(div);
      bus.CFG_MODE = mode;
`ifdef CLKDIV_PHASE_EN
      bus.CFG_PHASE = CNT_W'(phase);
`else
      if (phase != 0) $display("[TB] phase value %0d unused in this build", phase);
`endif
   endtask

   task automatic pushExpect(input logic [2:0] t, input logic [2:0] s, input string name);
      exp_t e;
      e.cyc  = edgeCnt + 1;
      e.tick = t;
      e.slow = s;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic step(input logic rst, input logic [2:0] en, input logic we,
                       input logic [1:0] ch, input int div, input logic mode, input int phase,
                       input logic [2:0] t, input logic [2:0] s, input string name);
      applyStimulus(rst, en, we, ch, div, mode, phase);
      pushExpect(t, s, name);
   endtask

   // Run ch0 for n edges; tickList holds the hand-computed edges (1-based) where TICK fires.
   task automatic runEdges(input string name, input int n, input logic [2:0] en,
                           input int wrEdge, input logic [1:0] wrCh, input int wrDiv,
                           input logic wrMode, input logic pulse, input logic slowInit);
      logic lvl;
      logic t;
      lvl = slowInit;
      for (int e = 1; e <= n; e++) begin
         t = 1'b0;
         foreach (tickList[k]) if (tickList[k] == e) t = 1'b1;
         if (t && !pulse) lvl = ~lvl;
         step(1'b0, en, (e == wrEdge), wrCh, wrDiv, wrMode, 0,
              {2'b00, t}, {2'b00, (pulse ? t : lvl)}, name);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if (e.cyc != edgeCnt) begin
         errors++;
         $display("[TB] FAIL %s: checked at edge %0d, required edge %0d", e.name, edgeCnt, e.cyc);
      end else if (bus.TICK !== e.tick || bus.SLOW_CLK !== e.slow) begin
         errors++;
         $display("[TB] FAIL %s edge %0d: TICK=%b SLOW_CLK=%b, required TICK=%b SLOW_CLK=%b",
                  e.name, edgeCnt, bus.TICK, bus.SLOW_CLK, e.tick, e.slow);
      end
   endtask

   // Monitor: on each falling edge, compare every expectation that belongs to the last rising edge.
   initial begin
      exp_t cur;
      forever begin
         @(negedge SYS_CLK);
         while (sb.size() > 0 && sb[0].cyc <= edgeCnt) begin
            cur = sb.pop_front();
            checkOutput(cur);
         end
      end
   end

   // Safety net so the run always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed stimulus.
   initial begin
      logic [2:0] t2;
      logic [2:0] s2;
      SYS_RST      = 1'b1;
      bus.CH_EN    = '0;
      bus.CFG_WE   = 1'b0;
      bus.CFG_CH   = '0;
      bus.CFG_DIV  = '0;
      bus.CFG_MODE = 1'b0;
`ifdef CLKDIV_PHASE_EN
      bus.CFG_PHASE = '0;
`endif

      // Reset with a config write that must be ignored.
      step(1'b1, 3'b000, 1'b1, 2'd0, 1, 1'b1, 0, 3'b000, 3'b000, "reset");
      step(1'b1, 3'b000, 1'b1, 2'd0, 1, 1'b1, 0, 3'b000, 3'b000, "reset");

      // Test 1: default divider 5 on ch0.
      tickList = '{6, 12, 18};
      runEdges("t1_div5", 18, 3'b001, 0, 2'd0, 0, 1'b0, 1'b0, 1'b0);

      // Test 2: ch1 div=0 programmed while idle.
      step(1'b0, 3'b000, 1'b1, 2'd1, 0, 1'b0, 0, 3'b000, 3'b000, "t2_idle_wr");
      step(1'b0, 3'b000, 1'b0, 2'd0, 0, 1'b0, 0, 3'b000, 3'b000, "t2_idle_load");
      for (int e = 1; e <= 6; e++) begin
         t2 = {1'b0, 1'b1, (e == 6)};
         s2 = {1'b0, (e % 2 == 1), (e == 6)};
         step(1'b0, 3'b011, 1'b0, 2'd0, 0, 1'b0, 0, t2, s2, "t2_div0");
      end
      step(1'b0, 3'b000, 1'b1, 2'd1, 5, 1'b0, 0, 3'b000, 3'b000, "t2_restore");

      // Test 3: mid-period write, then write on a terminal edge.
      tickList = '{6, 9, 12, 15};
      runEdges("t3_wr_mid", 15, 3'b001, 3, 2'd0, 2, 1'b0, 1'b0, 1'b0);
      tickList = '{3, 6, 12, 18};
      runEdges("t3_wr_term", 18, 3'b001, 3, 2'd0, 5, 1'b0, 1'b0, 1'b0);

      // Test 4: pulse mode div 3, then a write to out-of-range channel 3.
      tickList = '{6, 10, 14, 18, 22};
      runEdges("t4_mode1", 22, 3'b001, 1, 2'd0, 3, 1'b1, 1'b1, 1'b0);
      tickList = '{4, 8};
      runEdges("t4_bad_ch", 8, 3'b001, 2, 2'd3, 0, 1'b0, 1'b1, 1'b0);

      // Test 5: back to toggle mode, enable drop, re-enable, reset mid-count.
      tickList = '{4};
      runEdges("t5_mode0", 7, 3'b001, 1, 2'd0, 5, 1'b0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b0, 2'd0, 0, 1'b0, 0, 3'b000, 3'b000, "t5_drop");
      tickList = '{6};
      runEdges("t5_reen", 10, 3'b001, 7, 2'd0, 2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 3'b001, 1'b0, 2'd0, 0, 1'b0, 0, 3'b000, 3'b000, "t5_reset");
      step(1'b0, 3'b000, 1'b0, 2'd0, 0, 1'b0, 0, 3'b000, 3'b000, "t5_post_idle");
      tickList = '{6, 12};
      runEdges("t5_default_div", 12, 3'b001, 0, 2'd0, 0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b0, 2'd0, 0, 1'b0, 0, 3'b000, 3'b000, "t5_end_idle");

`ifdef CLKDIV_PHASE_EN
      // Test 6: start phase 4, then phase 9 clamped to the divider.
      step(1'b0, 3'b000, 1'b1, 2'd0, 5, 1'b0, 4, 3'b000, 3'b000, "t6_wr4");
      step(1'b0, 3'b000, 1'b0, 2'd0, 0, 1'b0, 0, 3'b000, 3'b000, "t6_load4");
      tickList = '{2, 8, 14};
      runEdges("t6_phase4", 14, 3'b001, 0, 2'd0, 0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b1, 2'd0, 5, 1'b0, 9, 3'b000, 3'b000, "t6_wr9");
      step(1'b0, 3'b000, 1'b0, 2'd0, 0, 1'b0, 0, 3'b000, 3'b000, "t6_load9");
      tickList = '{1, 7};
      runEdges("t6_phase9", 7, 3'b001, 0, 2'd0, 0, 1'b0, 1'b0, 1'b0);
`endif

      // Drain the scoreboard with a bounded wait.
      for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge SYS_CLK);
      #1;
      while (sb.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: expectation for edge %0d never compared", sb[0].name, sb[0].cyc);
         void'(sb.pop_front());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
